ram8_access_ctrl: RTL and testbench

//   Shares a single RAM8 (8 x 16-bit, ADDRESS/IN/LOAD/OUT) between two requesters.

---
 rtl/ram_ctrl_pkg.sv | 13 +
 rtl/ram8_access_ctrl_rr_arb2.sv | 21 ++
 rtl/ram8_access_ctrl.sv | 105 ++++++++++
 tb/tb_ram8_access_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM8 access controller: FSM state encodings and default widths.
package ram_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ram8_access_ctrl_rr_arb2.sv
// Combinational 2-way arbiter. Round-robin on ties by default;
// ARB_FIXED_PRIORITY_EN makes port 0 win every tie.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic any,
    output logic win
);

    always_comb begin
        any = req0 | req1;
`ifdef ARB_FIXED_PRIORITY_EN
        win = ~req0 & req1;
`else
        // On a tie the port that was not served last wins.
        win = (req0 & req1) ? ~last : req1;
`endif
    end

endmodule

// File: rtl/ram8_access_ctrl.sv
// Two-requester REQ/ACK front end for a single RAM8; fixed IDLE->GRANT->DONE sequence per op.
// Tie-break policy selected by ARB_FIXED_PRIORITY_EN (undefined: round-robin).
module ram8_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    state_t state;
    logic   last;
    logic   lat_port;
    logic   lat_we;
    logic   arb_any;
    logic   arb_win;

    rr_arb2 u_arb (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .any  (arb_any),
        .win  (arb_win)
    );

    // ram_address/ram_in double as the latched address/data: loaded once in IDLE
    // and held afterwards, so the RAM bus never changes outside a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last        <= 1'b1;
            lat_port    <= 1'b0;
            lat_we      <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            busy        <= 1'b0;
            ram_address <= '0;
            ram_in      <= '0;
            ram_load    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    ram_load <= 1'b0;
                    if (arb_any) begin
                        lat_port    <= arb_win;
                        lat_we      <= arb_win ? we1 : we0;
                        ram_address <= arb_win ? addr1 : addr0;
                        ram_in      <= arb_win ? wdata1 : wdata0;
                        ram_load    <= arb_win ? we1 : we0;
                        last        <= arb_win;
                        busy        <= 1'b1;
                        state       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    ram_load <= 1'b0;
                    if (!lat_we) begin
                        if (lat_port) rdata1 <= ram_out;
                        else          rdata0 <= ram_out;
                    end
                    ack0  <= ~lat_port;
                    ack1  <= lat_port;
                    state <= S_DONE;
                end
                S_DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    busy     <= 1'b0;
                    ram_load <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_access_ctrl.sv
// Scoreboard bench for ram8_access_ctrl with a behavioural RAM8 beside the DUT.
// Define ARB_FIXED_PRIORITY_EN for both DUT and bench to exercise the fixed-priority build.
module tb_ram8_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [2:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, ram_load;
    logic [15:0] rdata0, rdata1, ram_in, ram_out;
    logic [2:0]  ram_address;

    int checks = 0;
    int failures = 0;

    typedef struct {logic port; logic [15:0] data;} ack_exp_t;
    typedef struct {logic [2:0] addr; logic [15:0] data;} wr_exp_t;

    ack_exp_t    aq[$];
    wr_exp_t     wq[$];
    logic [15:0] ref_mem [8];
    logic [15:0] exp_rd [2];
    logic [15:0] mem [8];

    always #5 clk = ~clk;

    ram8_access_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
    );

    // RAM8: combinational read, write on rising edge when LOAD is high.
    assign ram_out = mem[ram_address];
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Record expectations in the order the arbiter is expected to serve the ops.
    task automatic expect_op(input int p, input logic we, input logic [2:0] a, input logic [15:0] d);
        ack_exp_t e;
        wr_exp_t  w;
        if (we) begin
            ref_mem[a] = d;
            w.addr = a;
            w.data = d;
            wq.push_back(w);
        end else begin
            exp_rd[p] = ref_mem[a];
        end
        e.port = p[0];
        e.data = exp_rd[p];
        aq.push_back(e);
    endtask

    task automatic op(input int p, input logic we, input logic [2:0] a, input logic [15:0] d);
        bit done = 0;
        if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((p == 0) ? ack0 : ack1) done = 1;
        end
        if (!done) check_eq("ack_timeout", 32'd0, 32'd1);
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    logic     prev_load = 1'b0;
    logic     mon_port;
    ack_exp_t mon_e;
    wr_exp_t  mon_w;

    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("ack_excl", 32'(ack0 & ack1), 32'd0);
            if (ram_load) begin
                check_eq("load_consec", 32'(prev_load), 32'd0);
                if (wq.size() == 0) check_eq("load_unexp", 32'd1, 32'd0);
                else begin
                    mon_w = wq.pop_front();
                    check_eq("ram_addr", 32'(ram_address), 32'(mon_w.addr));
                    check_eq("ram_in", 32'(ram_in), 32'(mon_w.data));
                end
            end
            prev_load = ram_load;
            if (ack0 | ack1) begin
                mon_port = ack1;
                check_eq("busy_done", 32'(busy), 32'd1);
                if (aq.size() == 0) check_eq("ack_unexp", 32'd1, 32'd0);
                else begin
                    mon_e = aq.pop_front();
                    check_eq("ack_port", 32'(mon_port), 32'(mon_e.port));
                    check_eq("rdata", 32'(mon_port ? rdata1 : rdata0), 32'(mon_e.data));
                end
            end
        end else begin
            prev_load = 1'b0;
        end
    end

    initial begin
        bit seen;
        for (int i = 0; i < 8; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_ram_load", 32'(ram_load), 32'd0);
        check_eq("rst_acks", 32'({ack0, ack1}), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
        check_eq("rst_ram_bus", 32'({ram_address, ram_in}), 32'd0);
        rst_n = 1'b1;

        // Write then read back from the other port.
        expect_op(0, 1'b1, 3'd5, 16'hAAAA);
        op(0, 1'b1, 3'd5, 16'hAAAA);
        expect_op(1, 1'b0, 3'd5, 16'h0);
        op(1, 1'b0, 3'd5, 16'h0);

        // Reset in the middle of a write grant: abandoned, nothing written.
        begin
            wr_exp_t w;
            w.addr = 3'd1;
            w.data = 16'hBEEF;
            wq.push_back(w);
        end
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd1; wdata0 = 16'hBEEF;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ram_load) seen = 1;
        end
        check_eq("grant_seen", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        check_eq("arst_ram_load", 32'(ram_load), 32'd0);
        check_eq("arst_acks", 32'({ack0, ack1}), 32'd0);
        check_eq("arst_rdata", 32'({rdata0, rdata1}), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("aborted_write", 32'(mem[1]), 32'd0);

        // Simultaneous writes to the same address: port 0 first, so port 1's data survives.
        expect_op(0, 1'b1, 3'd0, 16'h1111);
        expect_op(1, 1'b1, 3'd0, 16'h2222);
        fork
            op(0, 1'b1, 3'd0, 16'h1111);
            op(1, 1'b1, 3'd0, 16'h2222);
        join
        expect_op(0, 1'b0, 3'd0, 16'h0);
        op(0, 1'b0, 3'd0, 16'h0);
        expect_op(1, 1'b0, 3'd5, 16'h0);
        op(1, 1'b0, 3'd5, 16'h0);

        // Saturation: both ports keep requesting reads back to back.
`ifdef ARB_FIXED_PRIORITY_EN
        expect_op(0, 1'b0, 3'd5, 16'h0);
        expect_op(0, 1'b0, 3'd0, 16'h0);
        expect_op(0, 1'b0, 3'd5, 16'h0);
        expect_op(1, 1'b0, 3'd0, 16'h0);
        expect_op(1, 1'b0, 3'd5, 16'h0);
        expect_op(1, 1'b0, 3'd0, 16'h0);
`else
        expect_op(0, 1'b0, 3'd5, 16'h0);
        expect_op(1, 1'b0, 3'd0, 16'h0);
        expect_op(0, 1'b0, 3'd0, 16'h0);
        expect_op(1, 1'b0, 3'd5, 16'h0);
        expect_op(0, 1'b0, 3'd5, 16'h0);
        expect_op(1, 1'b0, 3'd0, 16'h0);
`endif
        fork
            begin
                op(0, 1'b0, 3'd5, 16'h0);
                op(0, 1'b0, 3'd0, 16'h0);
                op(0, 1'b0, 3'd5, 16'h0);
            end
            begin
                op(1, 1'b0, 3'd0, 16'h0);
                op(1, 1'b0, 3'd5, 16'h0);
                op(1, 1'b0, 3'd0, 16'h0);
            end
        join

        // Read of preloaded data: no RAM write may occur.
        mem[3] = 16'h5555;
        ref_mem[3] = 16'h5555;
        expect_op(0, 1'b0, 3'd3, 16'h0);
        op(0, 1'b0, 3'd3, 16'h0);
        check_eq("addr3_intact", 32'(mem[3]), 32'h5555);

`ifdef ARB_FIXED_PRIORITY_EN
        // Port 1 only gets through once port 0 stops requesting.
        expect_op(0, 1'b0, 3'd3, 16'h0);
        expect_op(0, 1'b0, 3'd3, 16'h0);
        expect_op(0, 1'b0, 3'd3, 16'h0);
        expect_op(1, 1'b0, 3'd0, 16'h0);
        fork
            begin
                op(0, 1'b0, 3'd3, 16'h0);
                op(0, 1'b0, 3'd3, 16'h0);
                op(0, 1'b0, 3'd3, 16'h0);
            end
            op(1, 1'b0, 3'd0, 16'h0);
        join
`endif

        for (int i = 0; i < 20 && (aq.size() + wq.size()) != 0; i++) @(negedge clk);
        check_eq("drain", 32'(aq.size() + wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
